// File: rtl/fetch_aligner_pkg.sv
// Shared constants and RVC detection for the fetch aligner.
package fetch_aligner_pkg;

    localparam logic [1:0]  OPC_RVC_MASK = 2'b11;
    localparam int unsigned HW_BYTES     = 2;
    localparam int unsigned W_BYTES      = 4;

    // A halfword starts a compressed instruction unless its two low bits are both set.
    function automatic logic is_rvc(input logic [15:0] hw);
        return (hw[1:0] & OPC_RVC_MASK) != OPC_RVC_MASK;
    endfunction

endpackage

// File: rtl/fetch_aligner_hw_buffer.sv
// align_hw_buffer: shift buffer of EW-bit entries with occupancy count,
// consume of 0..2 entries from the head and append of 0..2 entries behind the survivors.
module align_hw_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned EW    = 16,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            clear,
    input  logic [1:0]      consume,
    input  logic [1:0]      append,
    input  logic [2*EW-1:0] append_data,
    output logic [EW-1:0]   head0,
    output logic [EW-1:0]   head1,
    output logic [CW-1:0]   count
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [CW-1:0] base;
    logic [CW-1:0] count_d;

    // Shift out consumed entries, then drop new entries right after the survivors.
    always_comb begin
        base = count - CW'(consume);
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = '0;
            if (i + int'(consume) < int'(DEPTH)) begin
                mem_d[i] = mem_q[IW'(i + int'(consume))];
            end
        end
        for (int k = 0; k < 2; k++) begin
            if ((k < int'(append)) && (int'(base) + k < int'(DEPTH))) begin
                mem_d[IW'(int'(base) + k)] = append_data[k*EW +: EW];
            end
        end
        count_d = base + CW'(append);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count <= count_d;
            mem_q <= mem_d;
        end
    end

    assign head0 = mem_q[0];
    assign head1 = mem_q[1];

endmodule

// File: rtl/fetch_aligner.sv
// Fetch-word to decoder instruction aligner with PC tracking and redirect.
// Define ALIGN_RVC_EN for halfword buffering with compressed-instruction support.
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned BUF_HW = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic [PC_W-1:0] i_flush_pc,
    input  logic            i_fetch_valid,
    output logic            o_fetch_ready,
    input  logic [31:0]     i_fetch_word,
    output logic            o_dec_valid,
    input  logic            i_dec_ready,
    output logic [31:0]     o_dec_opcode,
    output logic [PC_W-1:0] o_dec_pc,
    output logic [PC_W-1:0] o_dec_next_pc,
    output logic            o_dec_rvc
);
`ifdef ALIGN_RVC_EN
    localparam int unsigned DEPTH = BUF_HW;
    localparam int unsigned EW    = 16;
`else
    localparam int unsigned DEPTH = 2;
    localparam int unsigned EW    = 32;
`endif
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   count;
    logic [EW-1:0]   head0;
    logic [EW-1:0]   head1;
    logic [1:0]      consume;
    logic [1:0]      append;
    logic [2*EW-1:0] append_data;
    logic [PC_W-1:0] pc;
    logic            head_rvc;
    logic            fire;
    logic            take;

    align_hw_buffer #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .CW    (CW)
    ) u_buf (
        .clk         (i_clk),
        .clear       (i_rst || i_flush),
        .consume     (consume),
        .append      (append),
        .append_data (append_data),
        .head0       (head0),
        .head1       (head1),
        .count       (count)
    );

    assign fire          = o_dec_valid && i_dec_ready;
    assign take          = i_fetch_valid && o_fetch_ready && !i_flush;
    assign o_dec_pc      = pc;
    assign o_dec_rvc     = head_rvc;
    assign o_dec_next_pc = pc + (head_rvc ? PC_W'(HW_BYTES) : PC_W'(W_BYTES));

`ifdef ALIGN_RVC_EN
    logic drop;
    logic unused_ok;

    assign unused_ok     = i_flush_pc[0];
    // Empty buffer reports a non-compressed head so idle outputs match reset values.
    assign head_rvc      = (count != '0) && is_rvc(head0);
    assign o_dec_valid   = !i_flush && ((count >= CW'(1) && head_rvc) || count >= CW'(2));
    assign o_dec_opcode  = head_rvc ? {16'h0000, head0} : {head1, head0};
    assign o_fetch_ready = !i_rst && (count <= CW'(BUF_HW - 2));
    assign consume       = fire ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
    assign append        = take ? (drop ? 2'd1 : 2'd2) : 2'd0;
    // A redirect into the upper half of a word skips the lower halfword of the next fetch.
    assign append_data   = drop ? {16'h0000, i_fetch_word[31:16]} : i_fetch_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc   <= '0;
            drop <= 1'b0;
        end else if (i_flush) begin
            pc   <= {i_flush_pc[PC_W-1:1], 1'b0};
            drop <= i_flush_pc[1];
        end else begin
            if (fire) begin
                pc <= o_dec_next_pc;
            end
            if (take) begin
                drop <= 1'b0;
            end
        end
    end
`else
    logic unused_ok;

    assign unused_ok     = ^{head1, i_flush_pc[1:0], BUF_HW[0]};
    assign head_rvc      = 1'b0;
    assign o_dec_valid   = !i_flush && (count >= CW'(1));
    assign o_dec_opcode  = head0;
    assign o_fetch_ready = !i_rst && (count < CW'(2));
    assign consume       = fire ? 2'd1 : 2'd0;
    assign append        = take ? 2'd1 : 2'd0;
    assign append_data   = {32'h0000_0000, i_fetch_word};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc <= '0;
        end else if (i_flush) begin
            pc <= {i_flush_pc[PC_W-1:2], 2'b00};
        end else if (fire) begin
            pc <= o_dec_next_pc;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner; follows ALIGN_RVC_EN the same way as the design.
module tb_fetch_aligner;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned BUF_HW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [PC_W-1:0] flush_pc;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [31:0]     fetch_word;
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_opcode;
    logic [PC_W-1:0] dec_pc;
    logic [PC_W-1:0] dec_next_pc;
    logic            dec_rvc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_aligner #(.PC_W(PC_W), .BUF_HW(BUF_HW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_flush_pc    (flush_pc),
        .i_fetch_valid (fetch_valid),
        .o_fetch_ready (fetch_ready),
        .i_fetch_word  (fetch_word),
        .o_dec_valid   (dec_valid),
        .i_dec_ready   (dec_ready),
        .o_dec_opcode  (dec_opcode),
        .o_dec_pc      (dec_pc),
        .o_dec_next_pc (dec_next_pc),
        .o_dec_rvc     (dec_rvc)
    );

    // Reference model: a plain queue of pending parcels plus the next instruction address.
`ifdef ALIGN_RVC_EN
    logic [15:0] mq[$];
    logic        mdrop;
`else
    logic [31:0] mq[$];
`endif
    logic [PC_W-1:0] mpc;
    logic [31:0]     seen_op[$];
    logic [PC_W-1:0] seen_pc[$];

    function automatic logic m_rvc();
`ifdef ALIGN_RVC_EN
        return (mq.size() > 0) && (mq[0][1:0] != 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_valid(input logic fl);
        if (fl || mq.size() == 0) return 1'b0;
        if (m_rvc()) return 1'b1;
`ifdef ALIGN_RVC_EN
        return mq.size() >= 2;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic m_ready();
`ifdef ALIGN_RVC_EN
        return mq.size() <= BUF_HW - 2;
`else
        return mq.size() < 2;
`endif
    endfunction

    function automatic logic [31:0] m_opcode();
`ifdef ALIGN_RVC_EN
        if (m_rvc()) return {16'h0000, mq[0]};
        return {mq[1], mq[0]};
`else
        return mq[0];
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance both.
    task automatic step(input logic fv, input logic [31:0] fw, input logic dr,
                        input logic fl, input logic [PC_W-1:0] fpc, output logic acc);
        logic ev;
        logic er;
        logic rv;
        fetch_valid = fv;
        fetch_word  = fw;
        dec_ready   = dr;
        flush       = fl;
        flush_pc    = fpc;
        #1;
        ev = m_valid(fl);
        er = m_ready();
        rv = m_rvc();
        check("dec_valid", dec_valid, ev);
        check("fetch_ready", fetch_ready, er);
        if (ev) begin
            check("dec_opcode", dec_opcode, m_opcode());
            check("dec_pc", dec_pc, mpc);
            check("dec_next_pc", dec_next_pc, mpc + (rv ? 2 : 4));
            check("dec_rvc", dec_rvc, rv);
        end
        acc = fv && fetch_ready && !fl;
        if (dec_valid && dr) begin
            seen_op.push_back(dec_opcode);
            seen_pc.push_back(dec_pc);
        end
        if (fl) begin
            mq.delete();
`ifdef ALIGN_RVC_EN
            mpc   = fpc & ~PC_W'(1);
            mdrop = fpc[1];
`else
            mpc   = fpc & ~PC_W'(3);
`endif
        end else begin
            if (ev && dr) begin
                void'(mq.pop_front());
                if (!rv) begin
`ifdef ALIGN_RVC_EN
                    void'(mq.pop_front());
`endif
                end
                mpc = mpc + (rv ? 2 : 4);
            end
            if (fv && er) begin
`ifdef ALIGN_RVC_EN
                if (mdrop) begin
                    mq.push_back(fw[31:16]);
                    mdrop = 1'b0;
                end else begin
                    mq.push_back(fw[15:0]);
                    mq.push_back(fw[31:16]);
                end
`else
                mq.push_back(fw);
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        flush       = 1'b0;
        flush_pc    = '0;
        fetch_valid = 1'b0;
        fetch_word  = '0;
        dec_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_dec_opcode", dec_opcode, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_next_pc", dec_next_pc, 32'h4);
        check("rst_dec_rvc", dec_rvc, 1'b0);
        check("rst_fetch_ready", fetch_ready, 1'b0);
        mq.delete();
        mpc = '0;
`ifdef ALIGN_RVC_EN
        mdrop = 1'b0;
`endif
        seen_op.delete();
        seen_pc.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, '0, acc);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] op, input logic [PC_W-1:0] pc);
        check({tag, "_present"}, seen_op.size() != 0, 1'b1);
        if (seen_op.size() != 0) begin
            check({tag, "_opcode"}, seen_op.pop_front(), op);
            check({tag, "_pc"}, seen_pc.pop_front(), pc);
        end
    endtask

    initial begin
        logic        acc;
        int          idx;
        logic [31:0] w;

        // Three plain 32-bit words stream straight through.
        do_reset();
        step(1'b1, 32'h00000013, 1'b1, 1'b0, '0, acc);
        step(1'b1, 32'h00000013, 1'b1, 1'b0, '0, acc);
        step(1'b1, 32'h00000013, 1'b1, 1'b0, '0, acc);
        drain(5);
        expect_out("t1_a", 32'h00000013, 'h0);
        expect_out("t1_b", 32'h00000013, 'h4);
        expect_out("t1_c", 32'h00000013, 'h8);
        check("t1_extra", seen_op.size(), 0);

        // Two compressed instructions in one word.
        do_reset();
        step(1'b1, 32'h45014505, 1'b1, 1'b0, '0, acc);
        drain(4);
`ifdef ALIGN_RVC_EN
        expect_out("t2_a", 32'h00004505, 'h0);
        expect_out("t2_b", 32'h00004501, 'h2);
`else
        expect_out("t2_a", 32'h45014505, 'h0);
`endif
        check("t2_extra", seen_op.size(), 0);

        // 32-bit instruction straddling two fetch words.
        do_reset();
        step(1'b1, 32'h05134505, 1'b1, 1'b0, '0, acc);
        step(1'b1, 32'h45010015, 1'b1, 1'b0, '0, acc);
        drain(5);
`ifdef ALIGN_RVC_EN
        expect_out("t3_a", 32'h00004505, 'h0);
        expect_out("t3_b", 32'h00150513, 'h2);
        expect_out("t3_c", 32'h00004501, 'h6);
`else
        expect_out("t3_a", 32'h05134505, 'h0);
        expect_out("t3_b", 32'h45010015, 'h4);
`endif
        check("t3_extra", seen_op.size(), 0);

        // Redirect into the upper half of a word with a full buffer.
        do_reset();
        step(1'b1, 32'h00000013, 1'b0, 1'b0, '0, acc);
        step(1'b1, 32'h00000013, 1'b0, 1'b0, '0, acc);
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 'h102, acc);
        check("t4_flush_accept", acc, 1'b0);
        step(1'b1, 32'h4505ABCD, 1'b1, 1'b0, '0, acc);
        drain(4);
`ifdef ALIGN_RVC_EN
        expect_out("t4_a", 32'h00004505, 'h102);
`else
        expect_out("t4_a", 32'h4505ABCD, 'h100);
`endif
        check("t4_extra", seen_op.size(), 0);

        // Decoder stall with back-pressure, then release: order and PCs intact.
        do_reset();
        idx = 0;
        for (int c = 0; c < 26; c++) begin
            w = 32'h00000013 | (32'(idx) << 20);
            step(idx < 8, w, c >= 6, 1'b0, '0, acc);
            if (acc) idx++;
            if (c == 5) check("t5_ready_low", fetch_ready, 1'b0);
        end
        check("t5_all_taken", idx, 8);
        for (int k = 0; k < 8; k++) begin
            expect_out("t5", 32'h00000013 | (32'(k) << 20), PC_W'(4 * k));
        end
        check("t5_extra", seen_op.size(), 0);

        // Back-to-back flushes with fetches in both cycles; the last target wins.
        do_reset();
        step(1'b1, 32'h00000013, 1'b1, 1'b0, '0, acc);
        step(1'b1, 32'h11111113, 1'b1, 1'b1, 'h200, acc);
        step(1'b1, 32'h22222213, 1'b1, 1'b1, 'h40, acc);
        step(1'b1, 32'h00100013, 1'b1, 1'b0, '0, acc);
        drain(4);
        expect_out("t6_a", 32'h00100013, 'h40);
        check("t6_extra", seen_op.size(), 0);

        // Reset in the middle of a stream clears everything.
        step(1'b1, 32'h05134505, 1'b0, 1'b0, '0, acc);
        step(1'b1, 32'h45010015, 1'b0, 1'b0, '0, acc);
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, '0, acc);
        check("t6_post_valid", dec_valid, 1'b0);
        check("t6_post_opcode", dec_opcode, 32'h0);
        check("t6_post_pc", dec_pc, 32'h0);
        check("t6_post_next_pc", dec_next_pc, 32'h4);
        check("t6_post_rvc", dec_rvc, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, PC_W'($urandom), acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
